free_list: RTL and testbench

//  Physical-register free list and allocator for the rename stage. Hands out up to

---
 rtl/free_list.sv | 133 +++++++++++++
 tb/tb_free_list.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list and allocator for the rename stage.
//   A circular buffer of free preg IDs with three pointers:
//     head  - speculative allocation pointer (advanced by rename)
//     rhead - retire head (where head must return on a flush)
//     tail  - insertion point for pregs reclaimed at commit
//   Up to FETCH_WIDTH IDs are handed out per cycle, same cycle as the request,
//   compacted in lane order. Up to COMMIT_WIDTH stale pregs are written back
//   per cycle. A flush rolls head back to the post-commit retire head.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high; reinitialises pointers and buffer
//   alloc_valid    a rename group is present this cycle
//   alloc_req      per-lane request for a destination preg
//   alloc_ready    the whole group can be served this cycle (combinational)
//   pdst_fl        per-lane {valid, preg id}; valid only for granted lanes
//   commit_valid   per-lane retire of an instruction with a destination
//   commit_free_id per-lane stale preg released back to the pool
//   flush          squash every speculative allocation
//   free_count     number of entries currently free (tail - head)
// -----------------------------------------------------------------------------
module free_list #(
    parameter int NUM_PREG     = 64,
    parameter int NUM_AREG     = 32,
    parameter int FETCH_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    localparam int DEPTH       = NUM_PREG - NUM_AREG,
    localparam int ID_W        = $clog2(NUM_PREG),
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int PTR_W       = IDX_W + 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                alloc_valid,
    input  logic [FETCH_WIDTH-1:0]              alloc_req,
    output logic                                alloc_ready,
    output logic [FETCH_WIDTH-1:0][ID_W:0]      pdst_fl,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid,
    input  logic [COMMIT_WIDTH-1:0][ID_W-1:0]   commit_free_id,
    input  logic                                flush,
    output logic [PTR_W-1:0]                    free_count
);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] rhead;
    logic [PTR_W-1:0] tail;

    logic [PTR_W-1:0] n_req;
    logic [PTR_W-1:0] n_commit;
    logic             fire;

    logic [PTR_W-1:0] alloc_off;
    logic [PTR_W-1:0] commit_off;
    logic [IDX_W-1:0] commit_idx [COMMIT_WIDTH];

    logic signed [PTR_W-1:0] retire_gap;
    logic [PTR_W-1:0]        tail_gap;

    function automatic logic [PTR_W-1:0] popcount(input logic [31:0] v);
        logic [PTR_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + PTR_W'(v[i]);
        end
        return cnt;
    endfunction

    assign n_req      = popcount(32'(alloc_req));
    assign n_commit   = popcount(32'(commit_valid));

    // Wrap-bit subtraction: 0 means empty, DEPTH means every entry is free.
    assign free_count  = tail - head;
    assign alloc_ready = !flush && (free_count >= n_req);
    assign fire        = alloc_valid && alloc_ready;

    // Requesting lanes take consecutive entries from head, skipping idle lanes.
    always_comb begin
        alloc_off = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            pdst_fl[i] = {fire && alloc_req[i], mem[IDX_W'(head + alloc_off)]};
            alloc_off  = alloc_off + PTR_W'(alloc_req[i]);
        end
    end

    // Reclaimed IDs are packed at tail in commit lane order.
    always_comb begin
        commit_off = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            commit_idx[j] = IDX_W'(tail + commit_off);
            commit_off    = commit_off + PTR_W'(commit_valid[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            rhead <= '0;
            tail  <= PTR_W'(DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= ID_W'(NUM_AREG + k);
            end
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (commit_valid[j]) begin
                    mem[commit_idx[j]] <= commit_free_id[j];
                end
            end
            tail  <= tail + n_commit;
            rhead <= rhead + n_commit;
            // Flush discards speculative pops; commits of this cycle still count.
            if (flush) begin
                head <= rhead + n_commit;
            end else if (fire) begin
                head <= head + n_req;
            end
        end
    end

    assign retire_gap = rhead - head;
    assign tail_gap   = tail - rhead;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (free_count <= PTR_W'(DEPTH));
            assert (retire_gap <= 0);
            assert (tail_gap == PTR_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Directed bench for free_list: reset state, lane-compacted allocation,
//   all-or-nothing grants at the empty boundary, commit without bypass,
//   flush rollback, reset override and a long wrap-around run checked
//   against a simple FIFO model of the free pool.
// -----------------------------------------------------------------------------
module tb_free_list;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc_valid;
    logic [1:0]       alloc_req;
    logic             alloc_ready;
    logic [1:0][6:0]  pdst_fl;
    logic [1:0]       commit_valid;
    logic [1:0][5:0]  commit_free_id;
    logic             flush;
    logic [5:0]       free_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .pdst_fl        (pdst_fl),
        .commit_valid   (commit_valid),
        .commit_free_id (commit_free_id),
        .flush          (flush),
        .free_count     (free_count)
    );

    function automatic int lane_v(input int i);
        return int'(pdst_fl[i][6]);
    endfunction

    function automatic int lane_id(input int i);
        return int'(pdst_fl[i][5:0]);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] r, input logic [1:0] cv,
                          input logic [5:0] c0, input logic [5:0] c1, input logic f);
        alloc_valid       = v;
        alloc_req         = r;
        commit_valid      = cv;
        commit_free_id[0] = c0;
        commit_free_id[1] = c1;
        flush             = f;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        set_in(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        #1;
    endtask

    int         fq[$];
    bit         in_use [64];
    logic [5:0] p0, p1;
    int         e0, e1;

    initial begin
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        #1;

        // Test 1: reset state and first allocation
        chk("rst_count", int'(free_count), 32);
        chk("rst_ready", int'(alloc_ready), 1);
        chk("rst_v0", lane_v(0), 0);
        chk("rst_v1", lane_v(1), 0);
        set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("t1_ready", int'(alloc_ready), 1);
        chk("t1_v0", lane_v(0), 1);
        chk("t1_id0", lane_id(0), 32);
        chk("t1_v1", lane_v(1), 1);
        chk("t1_id1", lane_id(1), 33);
        step();
        idle();
        chk("t1_count", int'(free_count), 30);

        // Test 2: only lane 1 requests, gets the head entry
        set_in(1'b1, 2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("t2_v0", lane_v(0), 0);
        chk("t2_v1", lane_v(1), 1);
        chk("t2_id1", lane_id(1), 34);
        step();
        idle();
        chk("t2_count", int'(free_count), 29);

        // Test 3: drain to one entry, then all-or-nothing at the boundary
        for (int k = 0; k < 14; k++) begin
            set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
            step();
        end
        idle();
        chk("t3_count1", int'(free_count), 1);
        set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("t3_ready_lo", int'(alloc_ready), 0);
        chk("t3_nov0", lane_v(0), 0);
        chk("t3_nov1", lane_v(1), 0);
        step();
        idle();
        chk("t3_nopop", int'(free_count), 1);
        set_in(1'b1, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("t3_ready_hi", int'(alloc_ready), 1);
        chk("t3_v0", lane_v(0), 1);
        chk("t3_id0", lane_id(0), 63);
        step();
        idle();
        chk("t3_count0", int'(free_count), 0);

        // Test 4: commit into an empty pool, no same-cycle bypass
        set_in(1'b1, 2'b11, 2'b11, 6'd5, 6'd7, 1'b0);
        chk("t4_ready_lo", int'(alloc_ready), 0);
        chk("t4_nov0", lane_v(0), 0);
        step();
        set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("t4_ready_hi", int'(alloc_ready), 1);
        chk("t4_id0", lane_id(0), 5);
        chk("t4_id1", lane_id(1), 7);
        step();
        idle();
        chk("t4_count", int'(free_count), 0);

        // Test 5: allocate 6, commit 2 with flush, speculative entries return
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
            step();
        end
        idle();
        chk("t5_count26", int'(free_count), 26);
        set_in(1'b1, 2'b01, 2'b11, 6'd3, 6'd4, 1'b1);
        chk("t5_flush_ready", int'(alloc_ready), 0);
        chk("t5_flush_v0", lane_v(0), 0);
        step();
        idle();
        chk("t5_count32", int'(free_count), 32);
        set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("t5_id0", lane_id(0), 34);
        chk("t5_id1", lane_id(1), 35);
        step();

        // Reset overrides a simultaneous alloc/commit/flush
        reset = 1'b1;
        set_in(1'b1, 2'b11, 2'b11, 6'd9, 6'd10, 1'b1);
        step();
        reset = 1'b0;
        idle();
        chk("rst2_count", int'(free_count), 32);
        set_in(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        chk("rst2_id0", lane_id(0), 32);
        chk("rst2_id1", lane_id(1), 33);

        // Test 6: long alloc/commit run across several pointer wraps
        do_reset();
        for (int i = 0; i < 64; i++) in_use[i] = (i < 32);
        fq.delete();
        for (int i = 32; i < 64; i++) fq.push_back(i);
        p0 = '0;
        p1 = '0;
        for (int k = 0; k < 80; k++) begin
            set_in(1'b1, 2'b11, (k > 0) ? 2'b11 : 2'b00, p0, p1, 1'b0);
            e0 = fq.pop_front();
            e1 = fq.pop_front();
            chk("w_ready", int'(alloc_ready), 1);
            chk("w_id0", lane_id(0), e0);
            chk("w_id1", lane_id(1), e1);
            chk("w_dup0", int'(in_use[lane_id(0)]), 0);
            in_use[lane_id(0)] = 1'b1;
            chk("w_dup1", int'(in_use[lane_id(1)]), 0);
            in_use[lane_id(1)] = 1'b1;
            if (k > 0) begin
                in_use[p0] = 1'b0;
                in_use[p1] = 1'b0;
                fq.push_back(int'(p0));
                fq.push_back(int'(p1));
            end
            p0 = 6'(e0);
            p1 = 6'(e1);
            step();
            chk("w_count", int'(free_count), 30);
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
